// File: rtl/switch_dequeue_scheduler_if.sv
// Signal bundle between the four show-ahead ingress FIFOs, the crossbar selects,
// the registered output ports and the statistics readback.
interface switch_dequeue_scheduler_if #(
    parameter int unsigned CNT_W = 16
);
    logic [7:0]       data0, data1, data2, data3;
    logic             empty0, empty1, empty2, empty3;
    logic             rdreq0, rdreq1, rdreq2, rdreq3;
    logic [2:0]       sel0, sel1, sel2, sel3;
    logic [7:0]       out_data0, out_data1, out_data2, out_data3;
    logic             out_valid0, out_valid1, out_valid2, out_valid3;
    logic             out_ready0, out_ready1, out_ready2, out_ready3;
    logic [CNT_W-1:0] fwd_count0, fwd_count1, fwd_count2, fwd_count3;
    logic [CNT_W-1:0] conflict_count;

    // Scheduler side.
    modport master (
        input  data0, data1, data2, data3,
        input  empty0, empty1, empty2, empty3,
        input  out_ready0, out_ready1, out_ready2, out_ready3,
        output rdreq0, rdreq1, rdreq2, rdreq3,
        output sel0, sel1, sel2, sel3,
        output out_data0, out_data1, out_data2, out_data3,
        output out_valid0, out_valid1, out_valid2, out_valid3,
        output fwd_count0, fwd_count1, fwd_count2, fwd_count3,
        output conflict_count
    );

    // FIFO / consumer / status side.
    modport slave (
        output data0, data1, data2, data3,
        output empty0, empty1, empty2, empty3,
        output out_ready0, out_ready1, out_ready2, out_ready3,
        input  rdreq0, rdreq1, rdreq2, rdreq3,
        input  sel0, sel1, sel2, sel3,
        input  out_data0, out_data1, out_data2, out_data3,
        input  out_valid0, out_valid1, out_valid2, out_valid3,
        input  fwd_count0, fwd_count1, fwd_count2, fwd_count3,
        input  conflict_count
    );
endinterface

// File: rtl/switch_dequeue_scheduler.sv
// Read side of the 4-port switch ingress FIFOs: per-output round-robin arbitration
// over FIFO heads, pop strobes, crossbar selects and registered output ports.
module switch_dequeue_scheduler #(
    parameter int unsigned NPORTS = 4,
    parameter int unsigned CNT_W  = 16
) (
    input logic                        clk,
    input logic                        reset,
    input logic                        enable,
    switch_dequeue_scheduler_if.master bus
);
    logic [7:0]        head       [NPORTS];
    logic [NPORTS-1:0] empty;
    logic [NPORTS-1:0] out_ready;
    logic [NPORTS-1:0] rdreq;
    logic [NPORTS-1:0] grant;
    logic [NPORTS-1:0] can_take;
    logic [1:0]        win        [NPORTS];
    logic [2:0]        sel        [NPORTS];
    logic              conflict;

    logic [1:0]        rr_q       [NPORTS];
    logic [NPORTS-1:0] out_valid_q;
    logic [7:0]        out_data_q [NPORTS];
    logic [CNT_W-1:0]  fwd_q      [NPORTS];
    logic [CNT_W-1:0]  conflict_q;

    assign head[0] = bus.data0;
    assign head[1] = bus.data1;
    assign head[2] = bus.data2;
    assign head[3] = bus.data3;
    assign empty     = {bus.empty3, bus.empty2, bus.empty1, bus.empty0};
    assign out_ready = {bus.out_ready3, bus.out_ready2, bus.out_ready1, bus.out_ready0};

    // Requests are gated by reset so nothing is popped during the reset cycle.
    always_comb begin
        logic [1:0] idx;
        logic [2:0] nreq;
        logic       found;
        rdreq    = '0;
        grant    = '0;
        can_take = '0;
        conflict = 1'b0;
        idx      = 2'd0;
        nreq     = 3'd0;
        found    = 1'b0;
        for (int j = 0; j < NPORTS; j++) begin
            win[j]      = 2'd0;
            sel[j]      = 3'b100;
            nreq        = 3'd0;
            found       = 1'b0;
            can_take[j] = !out_valid_q[j] || out_ready[j];
            for (int k = 0; k < NPORTS; k++) begin
                idx = rr_q[j] + 2'(k);
                if (reset && enable && !empty[idx] && head[idx][7:6] == 2'(j)) begin
                    nreq = nreq + 3'd1;
                    if (!found) begin
                        found  = 1'b1;
                        win[j] = idx;
                    end
                end
            end
            if (found && can_take[j]) begin
                grant[j]        = 1'b1;
                rdreq[win[j]]   = 1'b1;
                sel[j]          = {1'b0, win[j]};
                // Backpressure-only denials never reach here, so they are not counted.
                if (nreq > 3'd1) conflict = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int j = 0; j < NPORTS; j++) begin
                rr_q[j]       <= 2'd0;
                out_valid_q[j] <= 1'b0;
                out_data_q[j] <= 8'h00;
                fwd_q[j]      <= '0;
            end
            conflict_q <= '0;
        end else begin
            for (int j = 0; j < NPORTS; j++) begin
                if (grant[j]) begin
                    out_data_q[j]  <= head[win[j]];
                    out_valid_q[j] <= 1'b1;
                    rr_q[j]        <= win[j] + 2'd1;
                end else if (out_ready[j]) begin
                    out_valid_q[j] <= 1'b0;
                end
                if (out_valid_q[j] && out_ready[j] && fwd_q[j] != '1) begin
                    fwd_q[j] <= fwd_q[j] + CNT_W'(1);
                end
            end
            if (conflict && conflict_q != '1) begin
                conflict_q <= conflict_q + CNT_W'(1);
            end
        end
    end

    assign {bus.rdreq3, bus.rdreq2, bus.rdreq1, bus.rdreq0} = rdreq;
    assign bus.sel0 = sel[0];
    assign bus.sel1 = sel[1];
    assign bus.sel2 = sel[2];
    assign bus.sel3 = sel[3];
    assign bus.out_data0 = out_data_q[0];
    assign bus.out_data1 = out_data_q[1];
    assign bus.out_data2 = out_data_q[2];
    assign bus.out_data3 = out_data_q[3];
    assign {bus.out_valid3, bus.out_valid2, bus.out_valid1, bus.out_valid0} = out_valid_q;
    assign bus.fwd_count0 = fwd_q[0];
    assign bus.fwd_count1 = fwd_q[1];
    assign bus.fwd_count2 = fwd_q[2];
    assign bus.fwd_count3 = fwd_q[3];
    assign bus.conflict_count = conflict_q;
endmodule

// File: tb/tb_switch_dequeue_scheduler.sv
// Bench for switch_dequeue_scheduler: a vector table for single-cycle grants plus
// FIFO-model sequences scored against a reference arbiter and per-port scoreboards.
module tb_switch_dequeue_scheduler;
    logic       clk;
    logic       reset;
    logic       enable;
    logic [7:0] in_data [4];
    logic [3:0] in_empty;
    logic [3:0] in_ready;
    logic [3:0] rdy;

    int checks;
    int errors;

    switch_dequeue_scheduler_if #(.CNT_W(16)) bus ();

    switch_dequeue_scheduler #(.NPORTS(4), .CNT_W(16)) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .bus    (bus.master)
    );

    assign bus.data0 = in_data[0];
    assign bus.data1 = in_data[1];
    assign bus.data2 = in_data[2];
    assign bus.data3 = in_data[3];
    assign {bus.empty3, bus.empty2, bus.empty1, bus.empty0} = in_empty;
    assign {bus.out_ready3, bus.out_ready2, bus.out_ready1, bus.out_ready0} = in_ready;

    logic [3:0]  dut_rdreq;
    logic [11:0] dut_sel;
    logic [31:0] dut_od;
    logic [3:0]  dut_ov;
    assign dut_rdreq = {bus.rdreq3, bus.rdreq2, bus.rdreq1, bus.rdreq0};
    assign dut_sel   = {bus.sel3, bus.sel2, bus.sel1, bus.sel0};
    assign dut_od    = {bus.out_data3, bus.out_data2, bus.out_data1, bus.out_data0};
    assign dut_ov    = {bus.out_valid3, bus.out_valid2, bus.out_valid1, bus.out_valid0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Reference state.
    int         m_rr [4];
    logic [3:0] m_ov;
    int         m_fwd [4];
    int         m_conf;
    logic [7:0] fq [4][$];
    logic [7:0] sb [4][$];
    logic [3:0]  last_rdreq;
    logic [11:0] last_sel;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  empty;
        logic        en;
        logic [3:0]  exp_rdreq;
        logic [11:0] exp_sel;
        logic [3:0]  exp_ov;
        logic [31:0] exp_od;
        logic [15:0] exp_conf;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] fwd_of(input int j);
        case (j)
            0:       fwd_of = bus.fwd_count0;
            1:       fwd_of = bus.fwd_count1;
            2:       fwd_of = bus.fwd_count2;
            default: fwd_of = bus.fwd_count3;
        endcase
    endfunction

    // One clock of FIFO model + reference arbiter + scoreboard.
    task automatic step();
        logic [3:0]  e_rdreq;
        logic [11:0] e_sel;
        logic [3:0]  nv;
        logic [7:0]  exp_b;
        bit          conf;
        int          win;
        int          cnt;
        int          i;
        for (int p = 0; p < 4; p++) begin
            in_empty[p] = (fq[p].size() == 0);
            in_data[p]  = in_empty[p] ? 8'h3F : fq[p][0];
        end
        in_ready = rdy;
        #2;
        e_rdreq = '0;
        e_sel   = 12'h924;
        conf    = 0;
        nv      = m_ov;
        for (int j = 0; j < 4; j++) begin
            win = -1;
            cnt = 0;
            for (int k = 0; k < 4; k++) begin
                i = (m_rr[j] + k) % 4;
                if (reset && enable && !in_empty[i] && int'(in_data[i][7:6]) == j) begin
                    cnt++;
                    if (win < 0) win = i;
                end
            end
            if (win >= 0 && (!m_ov[j] || in_ready[j])) begin
                e_rdreq[win]     = 1'b1;
                e_sel[3*j +: 3]  = {1'b0, 2'(win)};
                sb[j].push_back(in_data[win]);
                m_rr[j] = (win + 1) % 4;
                nv[j]   = 1'b1;
                if (cnt > 1) conf = 1;
            end else if (in_ready[j]) begin
                nv[j] = 1'b0;
            end
        end
        chk("rdreq", 32'(dut_rdreq), 32'(e_rdreq));
        chk("sel", 32'(dut_sel), 32'(e_sel));
        last_rdreq = dut_rdreq;
        last_sel   = dut_sel;
        if (reset) begin
            for (int j = 0; j < 4; j++) begin
                if (m_ov[j] && in_ready[j]) begin
                    exp_b = (sb[j].size() > 0) ? sb[j].pop_front() : 8'hxx;
                    chk("out_data accepted", 32'(dut_od[8*j +: 8]), 32'(exp_b));
                    if (m_fwd[j] < 65535) m_fwd[j]++;
                end
            end
            if (conf && m_conf < 65535) m_conf++;
            for (int p = 0; p < 4; p++) if (e_rdreq[p]) void'(fq[p].pop_front());
            m_ov = nv;
        end else begin
            for (int j = 0; j < 4; j++) begin
                m_rr[j]  = 0;
                m_fwd[j] = 0;
                sb[j].delete();
            end
            m_ov   = '0;
            m_conf = 0;
        end
        @(posedge clk);
        #1;
        chk("out_valid", 32'(dut_ov), 32'(m_ov));
        chk("conflict_count", 32'(bus.conflict_count), 32'(m_conf));
        for (int j = 0; j < 4; j++) chk("fwd_count", 32'(fwd_of(j)), 32'(m_fwd[j]));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    task automatic run_until_idle(input int max_cycles);
        int n;
        n = 0;
        while ((fq[0].size() + fq[1].size() + fq[2].size() + fq[3].size()) != 0 || m_ov != 0) begin
            if (n >= max_cycles) begin
                checks++;
                errors++;
                $display("FAIL drain timeout: got %0d cycles required under %0d", n, max_cycles);
                return;
            end
            step();
            n++;
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b0;
        enable   = 1'b0;
        rdy      = 4'hF;
        in_ready = 4'hF;
        in_empty = 4'hF;
        for (int p = 0; p < 4; p++) begin
            in_data[p] = 8'h00;
            m_rr[p]    = 0;
            m_fwd[p]   = 0;
        end
        m_ov   = '0;
        m_conf = 0;

        vecs[0] = '{32'h00000085, 4'b1110, 1'b1, 4'b0001, 12'b100_000_100_100,
                    4'b0100, 32'h00850000, 16'd0};
        vecs[1] = '{32'hC4834201, 4'b0000, 1'b1, 4'b1111, 12'b011_010_001_000,
                    4'b1111, 32'hC4834201, 16'd0};
        vecs[2] = '{32'hC4834201, 4'b1111, 1'b1, 4'b0000, 12'b100_100_100_100,
                    4'b0000, 32'h00000000, 16'd0};
        vecs[3] = '{32'hC4834201, 4'b0000, 1'b0, 4'b0000, 12'b100_100_100_100,
                    4'b0000, 32'h00000000, 16'd0};
        vecs[4] = '{32'h44434241, 4'b0000, 1'b1, 4'b0001, 12'b100_100_000_100,
                    4'b0010, 32'h00004100, 16'd1};
        vecs[5] = '{32'h07C90500, 4'b0101, 1'b1, 4'b0010, 12'b100_100_100_001,
                    4'b0001, 32'h00000005, 16'd1};

        repeat (2) @(posedge clk);
        #1;
        chk("reset rdreq", 32'(dut_rdreq), 32'h0);
        chk("reset sel", 32'(dut_sel), 32'h924);
        chk("reset out_valid", 32'(dut_ov), 32'h0);
        chk("reset out_data", dut_od, 32'h0);
        chk("reset conflict", 32'(bus.conflict_count), 32'h0);

        // Single-cycle vector table, each from a fresh reset.
        for (int v = 0; v < 6; v++) begin
            reset    = 1'b0;
            in_empty = 4'hF;
            @(posedge clk);
            #1;
            reset    = 1'b1;
            enable   = vecs[v].en;
            in_ready = 4'hF;
            in_empty = vecs[v].empty;
            for (int p = 0; p < 4; p++) in_data[p] = vecs[v].data[8*p +: 8];
            #2;
            chk("vec rdreq", 32'(dut_rdreq), 32'(vecs[v].exp_rdreq));
            chk("vec sel", 32'(dut_sel), 32'(vecs[v].exp_sel));
            @(posedge clk);
            #1;
            chk("vec out_valid", 32'(dut_ov), 32'(vecs[v].exp_ov));
            chk("vec out_data", dut_od, vecs[v].exp_od);
            chk("vec conflict", 32'(bus.conflict_count), 32'(vecs[v].exp_conf));
        end

        // All FIFOs empty: no pops.
        enable = 1'b1;
        rdy    = 4'hF;
        do_reset();
        repeat (4) step();
        chk("empty no rdreq", 32'(last_rdreq), 32'h0);

        // Four inputs contending for output 1.
        do_reset();
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 3; k++) fq[i].push_back(8'h40 | 8'(i * 4 + k));
        run_until_idle(40);
        chk("contention conflicts", 32'(bus.conflict_count), 32'd11);
        chk("contention fwd1", 32'(bus.fwd_count1), 32'd12);

        // Backpressure on output 3.
        do_reset();
        for (int k = 0; k < 6; k++) fq[3].push_back(8'hC0 + 8'(k));
        rdy = 4'hF;
        step();
        rdy = 4'b0111;
        repeat (5) begin
            step();
            chk("bp no pop", 32'(last_rdreq), 32'h0);
            chk("bp hold data", 32'(bus.out_data3), 32'hC0);
        end
        rdy = 4'hF;
        run_until_idle(20);
        chk("bp fwd3", 32'(bus.fwd_count3), 32'd6);
        chk("bp conflict", 32'(bus.conflict_count), 32'd0);

        // Enable low: drain only, pointers frozen.
        do_reset();
        fq[0].push_back(8'h01);
        fq[0].push_back(8'h02);
        fq[1].push_back(8'h43);
        fq[2].push_back(8'h06);
        step();
        enable = 1'b0;
        step();
        step();
        chk("disabled no rdreq", 32'(last_rdreq), 32'h0);
        chk("disabled drained", 32'(dut_ov), 32'h0);
        enable = 1'b1;
        step();
        chk("reenable sel0", 32'(last_sel[2:0]), 32'b010);
        run_until_idle(20);

        // Reset in the middle of contention traffic.
        do_reset();
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 2; k++) fq[i].push_back(8'h40 | 8'(i * 4 + k));
        step();
        step();
        chk("pre-reset valid1", 32'(dut_ov[1]), 32'd1);
        reset = 1'b0;
        step();
        chk("reset cycle rdreq", 32'(last_rdreq), 32'h0);
        reset = 1'b1;
        chk("mid reset out_valid", 32'(dut_ov), 32'h0);
        chk("mid reset out_data", dut_od, 32'h0);
        chk("mid reset conflict", 32'(bus.conflict_count), 32'h0);
        step();
        chk("restart sel1", 32'(last_sel[5:3]), 32'b000);
        run_until_idle(30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/switch_dequeue_scheduler.md
Name: switch_dequeue_scheduler

Overview:
Read side of the 4-port switch ingress FIFOs. Every cycle it inspects the head byte of the four show-ahead ingress FIFOs and arbitrates each output port round-robin among the inputs whose head targets it. It pops the winners and drives crossbar selects plus registered per-port output data with a valid/ready handshake. Forwarded-byte and contention counters feed the status readback path.

Parameters:
NPORTS, 4, number of input FIFOs and output ports (fixed at 4; 2-bit port index)
CNT_W, 16, width of statistics counters

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset (reset==0 resets on rising clk)
enable  input  1  1 = grants allowed; 0 = no new pops, output registers still drain
data0..data3  input  8 each  FIFO head byte (show-ahead; valid when emptyN==0); [7:6] destination port, [5:0] payload
empty0..empty3  input  1 each  FIFO empty flag
rdreq0..rdreq3  output  1 each  pop strobe to FIFO N (combinational, same cycle as grant)
sel0..sel3  output  3 each  crossbar select for output j: {1'b0, src[1:0]} when granted, 3'b100 when idle
out_data0..out_data3  output  8 each  registered forwarded byte for output j
out_valid0..out_valid3  output  1 each  out_dataj holds a byte
out_ready0..out_ready3  input  1 each  consumer accepts out_dataj this cycle
fwd_count0..fwd_count3  output  CNT_W each  bytes accepted on output j (saturating)
conflict_count  output  CNT_W  cycles with at least one arbitration loser (saturating)

Behaviour:
- Request: input i requests output d = datai[7:6] iff emptyi==0 and enable==1. Each input requests exactly one output per cycle.
- Output j can take a byte iff out_validj==0 or out_readyj==1 (same-cycle replacement allowed).
- Arbitration per output j: pointer rrj (2 bits, reset 0). Scan inputs rrj, rrj+1, ... mod 4; the first requester wins. Grant only if output j can take a byte. On grant, rrj <= winner+1 mod 4. With no grant, rrj is unchanged.
- A grant to input i on output j in cycle t asserts rdreqi in cycle t and drives selj = {0, i}. In cycle t+1: out_dataj = datai sampled at t (full byte, header unchanged) and out_validj = 1. Latency is 1 cycle from head-visible to out_valid.
- No grant and out_readyj==1: out_validj <= 0 next cycle. No grant and out_readyj==0: hold out_dataj and out_validj (stall; no pop).
- rdreqi is never asserted when emptyi==1. At most one rdreq per input and at most one grant per output per cycle. Up to 4 grants per cycle when destinations are distinct.
- Losers keep their head, get no rdreq, and retry next cycle.
- conflict_count += 1 in any cycle where some requesting input is not granted because another input won the same output. A backpressure-only denial does not count. The counter saturates at 2^CNT_W-1.
- fwd_countj += 1 on each cycle with out_validj && out_readyj. It saturates.
- enable==0: all rdreq=0, all sel=3'b100, pointers frozen. Output registers keep draining under ready.
- Reset (reset==0, sampled at posedge), including mid-transfer: rdreq*=0, sel*=3'b100, out_valid*=0, out_data*=8'h00, rr*=0, all counters 0. rdreq is gated by reset so no pop occurs during the reset cycle. A byte held in an output register is discarded.
- All outputs except rdreq and sel are registered. rdreq and sel are combinational from heads, empties, enable, valid/ready and pointers.

Test Plan:
- Single path: FIFO0 head 8'h85 (dest 2), all ready=1, enable=1 -> rdreq0=1 and sel2=3'b000 in cycle t; out_data2=8'h85, out_valid2=1 at t+1; fwd_count2=1 after the accept; other outputs idle (sel=3'b100).
- Parallel: heads 0x01 (dest 0), 0x42 (dest 1), 0x83 (dest 2), 0xC4 (dest 3) -> all four rdreq high in the same cycle; each byte appears on its own output at t+1; conflict_count stays 0.
- Contention/round-robin: inputs 0-3 each hold 3 bytes of dest 1 -> output 1 grants inputs 0,1,2,3,0,1,... on consecutive cycles; conflict_count increments on each cycle with ≥2 requesters (total 11 of 12 cycles).
- Backpressure: dest-3 byte stream, out_ready3=0 for 5 cycles after the first byte -> out_data3 holds, no rdreq, conflict_count unchanged; when ready returns to 1, one pop per cycle resumes and no byte is lost or duplicated.
- Empty and enable: all empty=1 -> no rdreq ever. With enable=0 and non-empty FIFOs -> no pop, a pending out_valid drains when ready=1, and rr pointers are unchanged on re-enable.
- Reset mid-operation: pull reset=0 while out_valid1=1 and a grant is pending -> next cycle all out_valid=0, counters 0, rdreq=0 during reset, pointers 0; after release, arbitration restarts from input 0.
